// File: rtl/bypass_seq_pkg.sv
// Shared types and helpers for the multi-cycle slice-serial adder/subtractor.
package bypass_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  // Width of the slice counter for W/N slices; never narrower than one bit.
  function automatic int unsigned slice_cnt_width(input int unsigned w, input int unsigned n);
    int unsigned s;
    s = w / n;
    return (s <= 1) ? 1 : $clog2(s);
  endfunction

endpackage

// File: rtl/bypass_add_sequencer_adder.sv
// N-bit carry-skip adder: ripple within K-bit blocks, carry bypasses a block
// whose bits all propagate.
module BypassAdder #(
  parameter int unsigned N = 32,
  parameter int unsigned K = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  localparam int unsigned NB = (N + K - 1) / K;

  logic c;
  logic blk_cin;
  logic p_all;
  logic p;

  always_comb begin
    sum     = '0;
    c       = cin;
    blk_cin = cin;
    p_all   = 1'b1;
    p       = 1'b0;
    for (int unsigned blk = 0; blk < NB; blk++) begin
      blk_cin = c;
      p_all   = 1'b1;
      for (int unsigned j = 0; j < K; j++) begin
        if (blk * K + j < N) begin
          p                = a[blk*K+j] ^ b[blk*K+j];
          sum[blk*K+j]     = p ^ c;
          c                = (a[blk*K+j] & b[blk*K+j]) | (p & c);
          p_all            = p_all & p;
        end
      end
      if (p_all) c = blk_cin;
    end
    cout = c;
  end

endmodule

// File: rtl/bypass_add_sequencer.sv
// W-bit add/subtract computed one N-bit slice per cycle through a shared
// BypassAdder, LSB slice first, with a registered inter-slice carry.
module bypass_add_sequencer
  import bypass_seq_pkg::*;
#(
  parameter int unsigned W = 128,
  parameter int unsigned N = 32,
  parameter int unsigned K = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_sub,
  input  logic         in_cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_cout,
  output logic         out_ovf,
  output logic         busy
);

  localparam int unsigned S  = W / N;
  localparam int unsigned SW = slice_cnt_width(W, N);

  if (W % N != 0) begin : g_bad_width
    $error("bypass_add_sequencer: W must be a multiple of N");
  end

  seq_state_e    state_q, state_d;
  logic [SW-1:0] slice_q, slice_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          carry_q, carry_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic          busy_q, busy_d;

  int unsigned   slice_idx;
  logic          last_slice;
  logic [N-1:0]  slice_sum;
  logic          slice_cout;

  assign slice_idx  = int'(slice_q);
  assign last_slice = (slice_q == SW'(S - 1));

  BypassAdder #(.N(N), .K(K)) u_slice (
    .a    (a_q[slice_idx*N +: N]),
    .b    (b_q[slice_idx*N +: N]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_comb begin
    state_d     = state_q;
    slice_d     = slice_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d        = in_a;
          b_d        = in_sub ? ~in_b : in_b;
          carry_d    = in_sub ? 1'b1 : in_cin;
          slice_d    = '0;
          state_d    = RUN;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      RUN: begin
        sum_d[slice_idx*N +: N] = slice_sum;
        carry_d                 = slice_cout;
        if (last_slice) begin
          // The top slice's Cout is reported only; it never wraps back in.
          slice_d     = '0;
          state_d     = DONE;
          cout_d      = slice_cout;
          ovf_d       = (a_q[W-1] == b_q[W-1]) && (slice_sum[N-1] != a_q[W-1]);
          out_valid_d = 1'b1;
        end else begin
          slice_d = slice_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      slice_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      slice_q     <= slice_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;
  assign out_ovf   = ovf_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_bypass_add_sequencer.sv
// Scoreboard bench for bypass_add_sequencer at W=128, N=32, K=4.
module tb_bypass_add_sequencer;

  localparam int unsigned W = 128;
  localparam int unsigned N = 32;
  localparam int unsigned K = 4;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_sub;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;
  logic         busy;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  bypass_add_sequencer #(.W(W), .N(N), .K(K)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sub, input logic cin);
    exp_t         e;
    logic [W:0]   r;
    logic [W-1:0] bb;
    logic         c;
    bb     = sub ? ~b : b;
    c      = sub ? 1'b1 : cin;
    r      = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c};
    e.sum  = r[W-1:0];
    e.cout = r[W];
    e.ovf  = (a[W-1] == bb[W-1]) && (r[W-1] != a[W-1]);
    return e;
  endfunction

  // Called at a negedge in IDLE; returns at the first negedge after acceptance.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input logic cin);
    int t;
    in_a     = a;
    in_b     = b;
    in_sub   = sub;
    in_cin   = cin;
    in_valid = 1'b1;
    sb.push_back(model(a, b, sub, cin));
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    // Scramble inputs to prove the operands were latched.
    in_a   = {4{$urandom()}};
    in_b   = {4{$urandom()}};
    in_sub = ~sub;
    in_cin = ~cin;
    check("run_in_ready", W'(in_ready), W'(1'b0));
    check("run_busy", W'(busy), W'(1'b1));
  endtask

  // Starts at the first negedge after acceptance; waits for out_valid and scores.
  task automatic wait_result(output exp_t e);
    int lat;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", W'(lat), W'(4));
    e = sb.pop_front();
    check("out_sum", out_sum, e.sum);
    check("out_cout", W'(out_cout), W'(e.cout));
    check("out_ovf", W'(out_ovf), W'(e.ovf));
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("rel_out_valid", W'(out_valid), W'(1'b0));
    check("rel_in_ready", W'(in_ready), W'(1'b1));
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic cin);
    exp_t e;
    start_op(a, b, sub, cin);
    wait_result(e);
    release_result();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    exp_t         e;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_sub    = 1'b0;
    in_cin    = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", W'(in_ready), W'(1'b1));
    check("rst_out_valid", W'(out_valid), W'(1'b0));
    check("rst_busy", W'(busy), W'(1'b0));
    check("rst_out_sum", out_sum, '0);
    check("rst_out_cout", W'(out_cout), W'(1'b0));
    check("rst_out_ovf", W'(out_ovf), W'(1'b0));

    run_op(128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'd1, 1'b0, 1'b0);
    run_op('1, '0, 1'b0, 1'b1);
    run_op(128'd5, 128'd7, 1'b1, 1'b0);
    run_op({1'b0, {(W-1){1'b1}}}, 128'd1, 1'b0, 1'b0);
    run_op({1'b1, {(W-1){1'b0}}}, 128'd1, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      ra = {$urandom(), $urandom(), $urandom(), $urandom()};
      rb = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_op(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Backpressure with a second request held throughout DONE.
    start_op(128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321, 128'h1111_1111_1111_1111_1111_1111_1111_1111,
             1'b0, 1'b1);
    wait_result(e);
    in_a     = 128'h00FF_00FF_00FF_00FF_00FF_00FF_00FF_00FF;
    in_b     = 128'h0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F;
    in_sub   = 1'b1;
    in_cin   = 1'b0;
    in_valid = 1'b1;
    sb.push_back(model(in_a, in_b, in_sub, in_cin));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_out_valid", W'(out_valid), W'(1'b1));
      check("bp_in_ready", W'(in_ready), W'(1'b0));
      check("bp_out_sum", out_sum, e.sum);
      check("bp_out_cout", W'(out_cout), W'(e.cout));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_idle_in_ready", W'(in_ready), W'(1'b1));
    check("bp_idle_out_valid", W'(out_valid), W'(1'b0));
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_second_busy", W'(busy), W'(1'b1));
    wait_result(e);
    release_result();

    // Reset while slice 2 is about to be processed; the operation is dropped.
    in_a     = '1;
    in_b     = '1;
    in_sub   = 1'b0;
    in_cin   = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_out_valid", W'(out_valid), W'(1'b0));
    check("mid_rst_in_ready", W'(in_ready), W'(1'b1));
    check("mid_rst_busy", W'(busy), W'(1'b0));
    check("mid_rst_out_sum", out_sum, '0);
    repeat (2) @(negedge clk);
    check("post_rst_out_valid", W'(out_valid), W'(1'b0));
    start_op(128'd3, 128'd4, 1'b0, 1'b0);
    wait_result(e);
    check("post_rst_seven", out_sum, 128'd7);
    release_result();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
